// File: rtl/scaler_window_feeder.sv
// scaler_window_feeder: feeds a 5-pixel source window (B4..B0) and 3-deep target history (T1..T3) to a scaler, emitting OUT_PER_IN targets per window position; ports: clk/rst, s_valid/s_ready/s_pixel/s_last source in, tpix scaler result in, m_valid/m_ready/m_pixel/m_last target out
module scaler_window_feeder #(
  parameter int OUT_PER_IN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_pixel,
  input  logic       s_last,
  output logic [7:0] B4,
  output logic [7:0] B3,
  output logic [7:0] B2,
  output logic [7:0] B1,
  output logic [7:0] B0,
  output logic [7:0] T1,
  output logic [7:0] T2,
  output logic [7:0] T3,
  input  logic [7:0] tpix,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_pixel,
  output logic       m_last
);
  localparam logic [1:0] FILL = 2'd0, EMIT = 2'd1, LOAD = 2'd2;
  localparam logic [2:0] PMAX = 3'(OUT_PER_IN - 1);
  logic [1:0] state;
  logic [2:0] fill, phase;
  logic last_flag, s_hs, m_hs, wrap;
  assign s_ready = state == FILL || state == LOAD;
  assign m_valid = state == EMIT;
  assign m_pixel = tpix;
  assign wrap = phase == PMAX;
  assign m_last = m_valid && wrap && last_flag;
  assign s_hs = s_valid && s_ready;
  assign m_hs = m_valid && m_ready;
  always_ff @(posedge clk)
    if (rst || (m_hs && m_last)) begin
      state <= FILL;
      {B4, B3, B2, B1, B0} <= '0;
      {T1, T2, T3} <= '0;
      fill <= '0;
      phase <= '0;
      last_flag <= 1'b0;
    end else begin
      if (s_hs) {B4, B3, B2, B1, B0} <= {B3, B2, B1, B0, s_pixel};
      if (m_hs) begin
        {T3, T2, T1} <= {T2, T1, tpix};
        phase <= wrap ? 3'd0 : phase + 3'd1;
        if (wrap) state <= LOAD;
      end
      if (s_hs && state == FILL) begin
        fill <= fill + 3'd1;
        if (fill == 3'd4 || s_last) begin
          state <= EMIT;
          phase <= '0;
          last_flag <= s_last;
        end
      end
      if (s_hs && state == LOAD) begin
        state <= EMIT;
        phase <= '0;
        last_flag <= s_last;
      end
    end
endmodule

// File: tb/tb_scaler_window_feeder.sv
// tb_scaler_window_feeder: table-driven cycle vectors plus a beat scoreboard for scaler_window_feeder
module tb_scaler_window_feeder;
  logic clk = 0, rst = 1, s_valid = 0, s_last = 0, m_ready = 0;
  logic [7:0] s_pixel = 0, tpix = 8'h55;
  logic s_ready, m_valid, m_last;
  logic [7:0] B4, B3, B2, B1, B0, T1, T2, T3, m_pixel;
  int vecs = 0, miscompares = 0;
  typedef struct {
    logic r, sv;
    logic [7:0] px;
    logic sl, mr;
    logic [7:0] tp;
    logic sr, mv, ml;
    logic [39:0] b;
    logic [23:0] t;
  } vec_t;
  typedef struct {
    logic [7:0] pix;
    logic last;
  } beat_t;
  vec_t tbl[$];
  beat_t sb[$];
  localparam logic [39:0] W5 = 40'h909FA3A3A9;
  scaler_window_feeder #(.OUT_PER_IN(2)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel), .s_last(s_last),
    .B4(B4), .B3(B3), .B2(B2), .B1(B1), .B0(B0), .T1(T1), .T2(T2), .T3(T3), .tpix(tpix),
    .m_valid(m_valid), .m_ready(m_ready), .m_pixel(m_pixel), .m_last(m_last)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int step, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s step %0d: got %h want %h", name, step, act, exp);
    end
  endtask
  function automatic vec_t v(input logic r, input logic sv, input logic [7:0] px, input logic sl, input logic mr,
                             input logic [7:0] tp, input logic sr, input logic mv, input logic ml,
                             input logic [39:0] b, input logic [23:0] t);
    vec_t e;
    e.r = r; e.sv = sv; e.px = px; e.sl = sl; e.mr = mr; e.tp = tp;
    e.sr = sr; e.mv = mv; e.ml = ml; e.b = b; e.t = t;
    return e;
  endfunction
  task automatic fill5();
    tbl.push_back(v(0, 1, 8'h90, 0, 1, 8'h55, 1, 0, 0, 40'h0, 24'h0));
    tbl.push_back(v(0, 1, 8'h9F, 0, 1, 8'h55, 1, 0, 0, 40'h90, 24'h0));
    tbl.push_back(v(0, 1, 8'hA3, 0, 1, 8'h55, 1, 0, 0, 40'h909F, 24'h0));
    tbl.push_back(v(0, 1, 8'hA3, 0, 1, 8'h55, 1, 0, 0, 40'h909FA3, 24'h0));
    tbl.push_back(v(0, 1, 8'hA9, 0, 1, 8'h55, 1, 0, 0, 40'h909FA3A3, 24'h0));
  endtask
  always @(negedge clk)
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) chk("unexpected_beat", -1, {m_pixel, 7'd0, m_last}, 64'hDEAD);
      else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_pixel", -1, m_pixel, e.pix);
        chk("beat_last", -1, m_last, e.last);
      end
    end
  initial begin
    fill5();
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h55, 0, 1, 0, W5, 24'h0));
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h55, 0, 1, 0, W5, 24'h550000));
    tbl.push_back(v(0, 1, 8'hB0, 1, 1, 8'h55, 1, 0, 0, W5, 24'h555500));
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h55, 0, 1, 0, 40'h9FA3A3A9B0, 24'h555500));
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h55, 0, 1, 1, 40'h9FA3A3A9B0, 24'h555555));
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h55, 1, 0, 0, 40'h0, 24'h0));
    fill5();
    repeat (3) tbl.push_back(v(0, 0, 0, 0, 0, 8'h55, 0, 1, 0, W5, 24'h0));
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h55, 0, 1, 0, W5, 24'h0));
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h55, 0, 1, 0, W5, 24'h550000));
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h55, 1, 0, 0, W5, 24'h555500));
    tbl.push_back(v(0, 1, 8'hC0, 0, 1, 8'h55, 1, 0, 0, W5, 24'h555500));
    tbl.push_back(v(1, 0, 0, 0, 1, 8'h55, 0, 1, 0, 40'h9FA3A3A9C0, 24'h555500));
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h55, 1, 0, 0, 40'h0, 24'h0));
    fill5();
    tbl.push_back(v(0, 0, 0, 0, 0, 8'h55, 0, 1, 0, W5, 24'h0));
    tbl.push_back(v(1, 0, 0, 0, 0, 8'h55, 0, 1, 0, W5, 24'h0));
    tbl.push_back(v(0, 1, 8'h10, 0, 1, 8'h55, 1, 0, 0, 40'h0, 24'h0));
    tbl.push_back(v(0, 1, 8'h20, 0, 1, 8'h55, 1, 0, 0, 40'h10, 24'h0));
    tbl.push_back(v(0, 1, 8'h30, 1, 1, 8'h55, 1, 0, 0, 40'h1020, 24'h0));
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h11, 0, 1, 0, 40'h102030, 24'h0));
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h22, 0, 1, 1, 40'h102030, 24'h110000));
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h55, 1, 0, 0, 40'h0, 24'h0));
    fill5();
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h01, 0, 1, 0, W5, 24'h0));
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h02, 0, 1, 0, W5, 24'h010000));
    tbl.push_back(v(0, 1, 8'hAA, 0, 1, 8'h55, 1, 0, 0, W5, 24'h020100));
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h03, 0, 1, 0, 40'h9FA3A3A9AA, 24'h020100));
    tbl.push_back(v(0, 0, 0, 0, 1, 8'h04, 0, 1, 0, 40'h9FA3A3A9AA, 24'h030201));
    tbl.push_back(v(0, 0, 0, 0, 0, 8'h55, 1, 0, 0, 40'h9FA3A3A9AA, 24'h040302));
    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst = tbl[i].r;
      s_valid = tbl[i].sv;
      s_pixel = tbl[i].px;
      s_last = tbl[i].sl;
      m_ready = tbl[i].mr;
      tpix = tbl[i].tp;
      if (tbl[i].mv && tbl[i].mr && !tbl[i].r) begin
        beat_t e;
        e.pix = tbl[i].tp;
        e.last = tbl[i].ml;
        sb.push_back(e);
      end
      @(negedge clk);
      chk("s_ready", i, s_ready, tbl[i].sr);
      chk("m_valid", i, m_valid, tbl[i].mv);
      chk("m_last", i, m_last, tbl[i].ml);
      chk("window", i, {B4, B3, B2, B1, B0}, tbl[i].b);
      chk("history", i, {T1, T2, T3}, tbl[i].t);
      chk("m_pixel", i, m_pixel, tbl[i].tp);
    end
    @(posedge clk);
    #1;
    s_valid = 0;
    m_ready = 0;
    @(negedge clk);
    chk("beats_left", -1, sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule

// File: doc/scaler_window_feeder.md
SCALER_WINDOW_FEEDER -- requirements
Module: scaler_window_feeder

Interface
REQ-001 Parameter OUT_PER_IN, default 2 (legal 1..8): number of target pixels emitted per source-window position.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 s_valid  input  1  source pixel valid.
REQ-005 s_ready  output  1  feeder accepts a source pixel this cycle.
REQ-006 s_pixel  input  8  source pixel.
REQ-007 s_last  input  1  qualifies s_pixel as the last pixel of a line.
REQ-008 B4, B3, B2, B1, B0  output  8 each  source window to the scaler; B0 newest, B4 oldest.
REQ-009 T1, T2, T3  output  8 each  target history to the scaler; T1 most recent emitted target pixel.
REQ-010 tpix  input  8  scaler result, combinational from B4..B0 and T1..T3.
REQ-011 m_valid  output  1  target pixel valid.
REQ-012 m_ready  input  1  downstream accepts target pixel.
REQ-013 m_pixel  output  8  target pixel; equals tpix combinationally.
REQ-014 m_last  output  1  last target pixel of the line; meaningful only with m_valid.

Function
REQ-015 Source handshake completes when s_valid and s_ready are both 1 on a rising edge; target handshake when m_valid and m_ready are both 1.
REQ-016 States: FILL, EMIT, LOAD; s_ready is 1 exactly in FILL and LOAD, m_valid is 1 exactly in EMIT, so both are never 1 together.
REQ-017 Every accepted source pixel shifts the window: B4<=B3, B3<=B2, B2<=B1, B1<=B0, B0<=s_pixel.
REQ-018 FILL: 3-bit fill count increments per accepted pixel; on the 5th accepted pixel go to EMIT, phase<=0.
REQ-019 FILL with s_last on an accepted pixel before the 5th: shift it in, set last_flag, go to EMIT; unfilled window slots stay 0.
REQ-020 EMIT: on each target handshake T3<=T2, T2<=T1, T1<=tpix, phase increments.
REQ-021 EMIT, handshake with phase==OUT_PER_IN-1 and last_flag=0: go to LOAD.
REQ-022 EMIT, handshake with phase==OUT_PER_IN-1 and last_flag=1: m_last is 1 on that beat; next cycle state=FILL with B4..B0, T1..T3, fill count, phase and last_flag all 0.
REQ-023 m_last is 0 on every other beat.
REQ-024 LOAD: on accepted pixel shift window, last_flag<=s_last, phase<=0, go to EMIT; latency from source handshake to m_valid is 1 cycle.
REQ-025 EMIT with m_ready=0: m_valid held 1, B/T registers, phase and state unchanged.
REQ-026 s_valid=0 in FILL or LOAD: no state change.
REQ-027 Phase counter is 3 bits; it never exceeds OUT_PER_IN-1.

Reset
REQ-028 rst=1 at a rising edge, in any state including mid-EMIT: state<=FILL; B4..B0, T1..T3, fill count, phase and last_flag<=0.
REQ-029 After reset: s_ready=1, m_valid=0, m_last=0.
REQ-030 rst overrides any handshake in the same cycle; that handshake has no effect.

Verification
REQ-031 Setup: OUT_PER_IN=2, bench scaler model drives tpix=0x55. Feed 0x90,0x9F,0xA3,0xA3,0xA9 with m_ready=1 -> next cycle B4=0x90, B3=0x9F, B2=0xA3, B1=0xA3, B0=0xA9, T1..T3=0, m_valid=1, s_ready=0.
REQ-032 Continue from REQ-031 -> two beats of m_pixel=0x55; afterwards T1=T2=0x55, T3=0, state LOAD, s_ready=1.
REQ-033 Same setup with m_ready=0 for 3 cycles in EMIT -> m_valid stays 1 and B/T are unchanged; first handshake follows m_ready rising.
REQ-034 6th pixel 0xB0 with s_last=1 -> B0=0xB0, B4=0x9F; m_last=1 on the 2nd beat only, then FILL with all window and history registers 0.
REQ-035 Short line: 0x10, 0x20, then 0x30 with s_last=1 -> B2=0x10, B1=0x20, B0=0x30, B4=B3=0; two beats, m_last=1 on the 2nd.
REQ-036 rst=1 for one cycle during EMIT -> next cycle all B/T=0, m_valid=0, s_ready=1; a fresh 5-pixel fill reproduces REQ-031.
